// File: rtl/axi4_arbiter_2to1_if.sv
// rtl/axi4_arbiter_2to1_if.sv - AXI4 port bundle shared by the 2:1 arbiter's master and slave sides
//
// Purpose: one full AXI4 port (AR, R, AW, W, B channels) with a 64-bit data
// path and 32-bit addresses. ID_W sets the ID width; IDs are carried unchanged.
//
// Modports:
//   master - drives ar*/aw*/w* payload+valid, rready, bready; receives the readies, r* and b*
//   slave  - the mirror image, used where a port is accepted (arbiter inputs m0/m1)
interface axi4_arbiter_2to1_if #(
  parameter int ID_W = 4
);
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;

  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wvalid;
  logic            wready;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;

  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi4_arbiter_2to1.sv
// rtl/axi4_arbiter_2to1.sv - two-master AXI4 arbiter sharing one 64-bit AXI4 port
//
// Purpose: master 0 and master 1 share the out port. Reads and writes are
// arbitrated by independent FSMs, one outstanding transaction per direction.
// Responses go back to the master that won that direction's address phase.
// Payload fields (id, addr, len, size, burst, data, strb, resp, last) pass
// through unmodified; data/response channels are combinational.
//
// Ports:
//   clock  - sole clock, rising edge
//   resetn - asynchronous active-low reset; all valids/readies drop at once
//   m0, m1 - upstream masters (slave modport of axi4_arbiter_2to1_if)
//   out    - shared downstream port toward the width converter (master modport)
//   ID width is set by the ID_W parameter of the connected interface instances.
//
// Configuration macro: AXI4_ARB_ROUND_ROBIN_EN
//   defined   - round-robin on ties, separate last-grant bit per direction
//               (reset value 1, so master 0 wins the first tie)
//   undefined - fixed priority, master 0 always wins a tie
module axi4_arbiter_2to1 (
  input  logic                  clock,
  input  logic                  resetn,
  axi4_arbiter_2to1_if.slave    m0,
  axi4_arbiter_2to1_if.slave    m1,
  axi4_arbiter_2to1_if.master   out
);

  typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_e;
  typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wstate_e;

  rstate_e rstate_q, rstate_d;
  wstate_e wstate_q, wstate_d;
  logic    rgrant_q, rgrant_d;   // 0 = master 0, 1 = master 1
  logic    wgrant_q, wgrant_d;
  logic    rpick, wpick;         // winner if arbitration happened this cycle

  // Granted master's handshake-side signals
  logic sel_arvalid, sel_rready;
  logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic ar_hs, aw_hs;

  assign sel_arvalid = rgrant_q ? m1.arvalid : m0.arvalid;
  assign sel_rready  = rgrant_q ? m1.rready  : m0.rready;
  assign sel_awvalid = wgrant_q ? m1.awvalid : m0.awvalid;
  assign sel_wvalid  = wgrant_q ? m1.wvalid  : m0.wvalid;
  assign sel_wlast   = wgrant_q ? m1.wlast   : m0.wlast;
  assign sel_bready  = wgrant_q ? m1.bready  : m0.bready;

  assign ar_hs = (rstate_q == RADDR) && sel_arvalid && out.arready;
  assign aw_hs = (wstate_q == WADDR) && sel_awvalid && out.awready;

`ifdef AXI4_ARB_ROUND_ROBIN_EN
  logic rprev_q, wprev_q;        // master granted at the last address handshake

  // On a tie the master not granted last time wins; otherwise the lone requester.
  assign rpick = (m0.arvalid && m1.arvalid) ? ~rprev_q : ~m0.arvalid;
  assign wpick = (m0.awvalid && m1.awvalid) ? ~wprev_q : ~m0.awvalid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rprev_q <= 1'b1;
      wprev_q <= 1'b1;
    end else begin
      if (ar_hs) rprev_q <= rgrant_q;
      if (aw_hs) wprev_q <= wgrant_q;
    end
  end
`else
  // Master 0 wins whenever it requests.
  assign rpick = ~m0.arvalid;
  assign wpick = ~m0.awvalid;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rstate_q <= RIDLE;
      wstate_q <= WIDLE;
      rgrant_q <= 1'b0;
      wgrant_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
      rgrant_q <= rgrant_d;
      wgrant_q <= wgrant_d;
    end
  end

  // Payload muxes: valid gating below makes these don't-care outside their phase.
  assign out.arid    = rgrant_q ? m1.arid    : m0.arid;
  assign out.araddr  = rgrant_q ? m1.araddr  : m0.araddr;
  assign out.arlen   = rgrant_q ? m1.arlen   : m0.arlen;
  assign out.arsize  = rgrant_q ? m1.arsize  : m0.arsize;
  assign out.arburst = rgrant_q ? m1.arburst : m0.arburst;

  assign out.awid    = wgrant_q ? m1.awid    : m0.awid;
  assign out.awaddr  = wgrant_q ? m1.awaddr  : m0.awaddr;
  assign out.awlen   = wgrant_q ? m1.awlen   : m0.awlen;
  assign out.awsize  = wgrant_q ? m1.awsize  : m0.awsize;
  assign out.awburst = wgrant_q ? m1.awburst : m0.awburst;

  assign out.wdata   = wgrant_q ? m1.wdata   : m0.wdata;
  assign out.wstrb   = wgrant_q ? m1.wstrb   : m0.wstrb;
  assign out.wlast   = sel_wlast;

  assign m0.rid   = out.rid;
  assign m0.rdata = out.rdata;
  assign m0.rresp = out.rresp;
  assign m0.rlast = out.rlast;
  assign m1.rid   = out.rid;
  assign m1.rdata = out.rdata;
  assign m1.rresp = out.rresp;
  assign m1.rlast = out.rlast;

  assign m0.bid   = out.bid;
  assign m0.bresp = out.bresp;
  assign m1.bid   = out.bid;
  assign m1.bresp = out.bresp;

  // Read FSM: next state and handshake routing
  always_comb begin
    rstate_d    = rstate_q;
    rgrant_d    = rgrant_q;
    out.arvalid = 1'b0;
    out.rready  = 1'b0;
    m0.arready  = 1'b0;
    m1.arready  = 1'b0;
    m0.rvalid   = 1'b0;
    m1.rvalid   = 1'b0;
    case (rstate_q)
      RIDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          rgrant_d = rpick;
          rstate_d = RADDR;
        end
      end
      RADDR: begin
        out.arvalid = sel_arvalid;
        m0.arready  = ~rgrant_q & out.arready;
        m1.arready  =  rgrant_q & out.arready;
        if (ar_hs) rstate_d = RDATA;
      end
      RDATA: begin
        out.rready = sel_rready;
        m0.rvalid  = ~rgrant_q & out.rvalid;
        m1.rvalid  =  rgrant_q & out.rvalid;
        if (out.rvalid && sel_rready && out.rlast) rstate_d = RIDLE;
      end
      default: rstate_d = RIDLE;
    endcase
  end

  // Write FSM: next state and handshake routing. wready is only ever raised
  // in WDATA, so W data offered ahead of AW simply waits.
  always_comb begin
    wstate_d    = wstate_q;
    wgrant_d    = wgrant_q;
    out.awvalid = 1'b0;
    out.wvalid  = 1'b0;
    out.bready  = 1'b0;
    m0.awready  = 1'b0;
    m1.awready  = 1'b0;
    m0.wready   = 1'b0;
    m1.wready   = 1'b0;
    m0.bvalid   = 1'b0;
    m1.bvalid   = 1'b0;
    case (wstate_q)
      WIDLE: begin
        if (m0.awvalid || m1.awvalid) begin
          wgrant_d = wpick;
          wstate_d = WADDR;
        end
      end
      WADDR: begin
        out.awvalid = sel_awvalid;
        m0.awready  = ~wgrant_q & out.awready;
        m1.awready  =  wgrant_q & out.awready;
        if (aw_hs) wstate_d = WDATA;
      end
      WDATA: begin
        out.wvalid = sel_wvalid;
        m0.wready  = ~wgrant_q & out.wready;
        m1.wready  =  wgrant_q & out.wready;
        if (sel_wvalid && out.wready && sel_wlast) wstate_d = WRESP;
      end
      WRESP: begin
        out.bready = sel_bready;
        m0.bvalid  = ~wgrant_q & out.bvalid;
        m1.bvalid  =  wgrant_q & out.bvalid;
        if (out.bvalid && sel_bready) wstate_d = WIDLE;
      end
    endcase
  end

endmodule
